// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared wishbone master port.
// m0 is the instruction-fetch path and m1 is the data-access path.
// Only one transaction is on the bus at a time. A grant is made in IDLE by
// round-robin or fixed priority. The bus side is frozen while BUSY, and the
// requesting master gets a single-cycle ack in DONE. A hung slave is cut off
// after TIMEOUT cycles with an error completion.
module bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_select_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_select_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_select_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Last BUSY cycle before an unanswered transaction is abandoned.
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        last_grant, last_grant_next;   // 0 = m0, 1 = m1
  logic        owner, owner_next;             // master holding the bus
  logic [15:0] count, count_next;
  logic        pick;

  logic [31:0] addr_next, wdata_next;
  logic        we_next, stb_next;
  logic [3:0]  sel_next;
  logic [1:0]  grant_next;

  // Per-master views so the owner index can select directly.
  logic [31:0] rdata_q [2];
  logic        ack_q   [2];
  logic        err_q   [2];
  logic [31:0] rdata_next [2];
  logic        ack_next   [2];
  logic        err_next   [2];

  assign m0_data_o = rdata_q[0];
  assign m1_data_o = rdata_q[1];
  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m0_err_o  = err_q[0];
  assign m1_err_o  = err_q[1];

  // Arbitration: a lone requester wins; a tie goes to m0 (fixed) or to the
  // master that did not own the bus last time (round-robin).
  always_comb begin
    pick = 1'b0;
    if (m0_req_i && m1_req_i) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (m1_req_i) begin
      pick = 1'b1;
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    owner_next      = owner;
    count_next      = count;
    addr_next       = bus_addr_o;
    wdata_next      = bus_data_o;
    we_next         = bus_we_o;
    sel_next        = bus_select_o;
    stb_next        = bus_stb_o;
    grant_next      = grant_o;
    rdata_next      = rdata_q;
    ack_next        = ack_q;
    err_next        = err_q;

    case (state)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_next = pick;
          addr_next  = pick ? m1_addr_i   : m0_addr_i;
          wdata_next = pick ? m1_data_i   : m0_data_i;
          we_next    = pick ? m1_we_i     : m0_we_i;
          sel_next   = pick ? m1_select_i : m0_select_i;
          stb_next   = 1'b1;
          grant_next = pick ? 2'b10 : 2'b01;
          count_next = 16'd0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A slave ack in the final allowed cycle still counts as success.
        if (bus_ack_i) begin
          rdata_next[owner] = bus_data_i;
          ack_next[owner]   = 1'b1;
          err_next[owner]   = 1'b0;
          stb_next          = 1'b0;
          we_next           = 1'b0;
          sel_next          = 4'd0;
          state_next        = DONE;
        end else if (count == LAST_COUNT) begin
          rdata_next[owner] = 32'd0;
          ack_next[owner]   = 1'b1;
          err_next[owner]   = 1'b1;
          stb_next          = 1'b0;
          we_next           = 1'b0;
          sel_next          = 4'd0;
          state_next        = DONE;
        end else begin
          count_next = count + 16'd1;
        end
      end
      DONE: begin
        // Requests are ignored here so a master still holding req during
        // its ack cycle is not immediately re-granted.
        last_grant_next = owner;
        grant_next      = 2'b00;
        ack_next        = '{default: 1'b0};
        err_next        = '{default: 1'b0};
        rdata_next      = '{default: 32'd0};
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      count        <= 16'd0;
      bus_addr_o   <= 32'd0;
      bus_data_o   <= 32'd0;
      bus_we_o     <= 1'b0;
      bus_select_o <= 4'd0;
      bus_stb_o    <= 1'b0;
      grant_o      <= 2'b00;
      rdata_q      <= '{default: 32'd0};
      ack_q        <= '{default: 1'b0};
      err_q        <= '{default: 1'b0};
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      owner        <= owner_next;
      count        <= count_next;
      bus_addr_o   <= addr_next;
      bus_data_o   <= wdata_next;
      bus_we_o     <= we_next;
      bus_select_o <= sel_next;
      bus_stb_o    <= stb_next;
      grant_o      <= grant_next;
      rdata_q      <= rdata_next;
      ack_q        <= ack_next;
      err_q        <= err_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter.
// Instance 0 is round-robin with TIMEOUT=8, and instance 1 is fixed-priority
// with TIMEOUT=5. Both instances share the master-side stimulus, and each
// instance has its own slave. A transaction-level model predicts the grant
// edge, the done edge, the owner, and the captured fields of every bus cycle.
module tb_bus_arbiter;

  localparam int NCYC = 900;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // shared master-side stimulus
  logic        m_req   [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_we    [2];
  logic [3:0]  m_sel   [2];
  logic [31:0] bus_rdata;
  logic        bus_ack [2];

  // DUT outputs, indexed [instance] or [instance][master]
  logic [31:0] d_o [2][2];
  logic        a_o [2][2];
  logic        e_o [2][2];
  logic [31:0] b_addr [2];
  logic [31:0] b_data [2];
  logic        b_we   [2];
  logic [3:0]  b_sel  [2];
  logic        b_stb  [2];
  logic [1:0]  gnt    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bus_arbiter #(.FIXED_PRIO(gi), .TIMEOUT(gi == 0 ? 8 : 5)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m_req[0]), .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]),
      .m0_we_i(m_we[0]), .m0_select_i(m_sel[0]),
      .m0_data_o(d_o[gi][0]), .m0_ack_o(a_o[gi][0]), .m0_err_o(e_o[gi][0]),
      .m1_req_i(m_req[1]), .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]),
      .m1_we_i(m_we[1]), .m1_select_i(m_sel[1]),
      .m1_data_o(d_o[gi][1]), .m1_ack_o(a_o[gi][1]), .m1_err_o(e_o[gi][1]),
      .bus_addr_o(b_addr[gi]), .bus_data_o(b_data[gi]), .bus_we_o(b_we[gi]),
      .bus_select_o(b_sel[gi]), .bus_stb_o(b_stb[gi]),
      .bus_data_i(bus_rdata), .bus_ack_i(bus_ack[gi]), .grant_o(gnt[gi])
    );
  end

  // reference model state, one slot per instance
  bit          act   [2];
  bit          own   [2];
  bit          last  [2];
  bit          terr  [2];
  int          g_e   [2];
  int          d_e   [2];
  int          w_slv [2];
  int          free_e[2];
  logic [31:0] rdata [2];
  logic [31:0] cap_addr [2];
  logic [31:0] cap_data [2];
  logic        cap_we   [2];
  logic [3:0]  cap_sel  [2];
  bit          rst_done = 1'b0;
  int          rst_it = 0;

  function automatic int to_of(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // The inputs still on the pins at this negedge are the ones edge e sampled.
  task automatic model_step(input int k, input int e);
    bit win;
    int to;
    to = to_of(k);
    if (act[k]) begin
      if (e == d_e[k]) begin
        rdata[k] = terr[k] ? 32'd0 : bus_rdata;
        $display("txn i%0d m%0d addr=%h we=%0d %s", k, own[k], cap_addr[k], cap_we[k],
                 terr[k] ? "timeout" : "ok");
      end else if (e == d_e[k] + 1) begin
        act[k]    = 1'b0;
        free_e[k] = e + 1;
      end
    end else if (e >= free_e[k] && (m_req[0] || m_req[1])) begin
      if (m_req[0] && m_req[1]) win = (k == 1) ? 1'b0 : !last[k];
      else                      win = m_req[1];
      act[k]      = 1'b1;
      own[k]      = win;
      last[k]     = win;
      g_e[k]      = e;
      cap_addr[k] = m_addr[win];
      cap_data[k] = m_wdata[win];
      cap_we[k]   = m_we[win];
      cap_sel[k]  = m_sel[win];
      case ($urandom % 6)
        0, 1:    w_slv[k] = 0;
        2:       w_slv[k] = to - 1;
        default: w_slv[k] = int'($urandom_range(0, to + 1));
      endcase
      terr[k] = (w_slv[k] > to - 1);
      d_e[k]  = e + 1 + (terr[k] ? to - 1 : w_slv[k]);
    end
  endtask

  task automatic check_inst(input int k, input int e);
    bit busy, done, ack_exp;
    busy = act[k] && e < d_e[k];
    done = act[k] && e == d_e[k];
    check_val($sformatf("i%0d stb", k), 32'(b_stb[k]), 32'(busy));
    check_val($sformatf("i%0d grant", k), 32'(gnt[k]),
              (busy || done) ? (own[k] ? 32'd2 : 32'd1) : 32'd0);
    check_val($sformatf("i%0d we", k), 32'(b_we[k]), busy ? 32'(cap_we[k]) : 32'd0);
    check_val($sformatf("i%0d sel", k), 32'(b_sel[k]), busy ? 32'(cap_sel[k]) : 32'd0);
    if (busy) begin
      check_val($sformatf("i%0d addr", k), b_addr[k], cap_addr[k]);
      check_val($sformatf("i%0d wdata", k), b_data[k], cap_data[k]);
    end
    for (int j = 0; j < 2; j++) begin
      ack_exp = done && (32'(own[k]) == 32'(j));
      check_val($sformatf("i%0d m%0d ack", k, j), 32'(a_o[k][j]), 32'(ack_exp));
      check_val($sformatf("i%0d m%0d err", k, j), 32'(e_o[k][j]), 32'(ack_exp && terr[k]));
      if (ack_exp) check_val($sformatf("i%0d m%0d rdata", k, j), d_o[k][j], rdata[k]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s i%0d stb", tag, k), 32'(b_stb[k]), 32'd0);
      check_val($sformatf("%s i%0d grant", tag, k), 32'(gnt[k]), 32'd0);
      check_val($sformatf("%s i%0d we", tag, k), 32'(b_we[k]), 32'd0);
      check_val($sformatf("%s i%0d sel", tag, k), 32'(b_sel[k]), 32'd0);
      for (int j = 0; j < 2; j++) begin
        check_val($sformatf("%s i%0d m%0d ack", tag, k, j), 32'(a_o[k][j]), 32'd0);
        check_val($sformatf("%s i%0d m%0d err", tag, k, j), 32'(e_o[k][j]), 32'd0);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k]    = 1'b0;
      last[k]   = 1'b1;
      free_e[k] = cyc + 1;
    end
  endtask

  // Drive the inputs that the next rising edge (cyc+1) will sample.
  task automatic drive(input int it);
    int ph;
    int n;
    n = cyc + 1;
    if (rst_done && it < rst_it + 100) ph = 0;
    else if (it < 150)                 ph = 0;
    else if (it < 350)                 ph = 1;
    else if (!rst_done)                ph = 2;
    else                               ph = 1;
    for (int j = 0; j < 2; j++) begin
      case (ph)
        0:       m_req[j] = 1'b1;
        1:       m_req[j] = ($urandom % 3) != 0;
        default: m_req[j] = ($urandom % 8) == 0;
      endcase
      if ($urandom % 2 == 0) begin
        m_addr[j]  = $urandom;
        m_wdata[j] = $urandom;
        m_we[j]    = 1'($urandom % 2);
        m_sel[j]   = 4'($urandom % 16);
      end
    end
    bus_rdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      if (act[k] && n <= d_e[k]) bus_ack[k] = (n == g_e[k] + 1 + w_slv[k]);
      else                       bus_ack[k] = ($urandom % 4) == 0;
    end
  endtask

  initial begin
    int e;
    for (int j = 0; j < 2; j++) begin
      m_req[j] = 1'b0; m_addr[j] = '0; m_wdata[j] = '0; m_we[j] = 1'b0; m_sel[j] = '0;
      bus_ack[j] = 1'b0;
    end
    bus_rdata = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    model_reset();
    drive(0);
    for (int it = 0; it < NCYC; it++) begin
      @(negedge clk);
      e = cyc;
      for (int k = 0; k < 2; k++) begin
        model_step(k, e);
        check_inst(k, e);
      end
      if (!rst_done && it >= 450 && act[0] && e < d_e[0]) begin
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b1;
        model_reset();
        rst_done = 1'b1;
        rst_it   = it;
      end
      drive(it);
    end
    if (!rst_done) check_val("midop_reset_reached", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that shares the single wishbone master port of the system bus between the CPU instruction-fetch path (m0) and the CPU data-access path (m1).
- Sits between the CPU memory interfaces and the bus address decoder. Serialises one transaction at a time.
- Grants by round-robin or fixed priority.
- A bus timeout completes hung transactions with an error to the requesting master.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0 and m1; 1 = m0 always wins a tie.
- TIMEOUT, 1024: cycles in BUSY without bus_ack_i before an error completion. Legal range 2..65535.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req_i  in  1  m0 transaction request; held until m0_ack_o
- m0_addr_i  in  32  m0 address
- m0_data_i  in  32  m0 write data
- m0_we_i  in  1  m0 write enable
- m0_select_i  in  4  m0 byte select
- m0_data_o  out  32  m0 read data; valid while m0_ack_o=1
- m0_ack_o  out  1  m0 completion pulse
- m0_err_o  out  1  m0 timeout flag; qualified by m0_ack_o
- m1_req_i, m1_addr_i, m1_data_i, m1_we_i, m1_select_i, m1_data_o, m1_ack_o, m1_err_o: identical to the m0 set, for master 1
- bus_addr_o  out  32  to bus master port
- bus_data_o  out  32  write data to bus
- bus_we_o  out  1  write enable to bus
- bus_select_o  out  4  byte select to bus
- bus_stb_o  out  1  transaction active
- bus_data_i  in  32  read data from bus
- bus_ack_i  in  1  slave acknowledge
- grant_o  out  2  debug: 2'b01 = m0 owns bus, 2'b10 = m1 owns bus, 2'b00 = idle

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - last_grant=1, so m0 wins the first tie.
  - Timeout counter is cleared.
  - Reset mid-transaction aborts immediately. No ack is delivered after reset.
- All outputs are registered.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If no req is asserted, stay in IDLE.
  - If only one master requests, grant it.
  - If both request: with FIXED_PRIO=1 grant m0. With FIXED_PRIO=0 grant the master that is not last_grant.
  - On a grant, capture that master's addr/data/we/select into the bus_* registers, set bus_stb_o=1, set grant_o, clear the counter and go to BUSY.
  - Request seen in cycle N gives bus_stb_o=1 in cycle N+1.
- BUSY:
  - bus_* outputs are held constant, independent of master input changes.
  - If bus_ack_i=1:
    - Capture bus_data_i into the granted master's data_o.
    - Set its ack_o=1 and err_o=0.
    - Set bus_stb_o=0, bus_we_o=0, bus_select_o=0.
    - Go to DONE.
  - Else if counter==TIMEOUT-1:
    - Set the granted master's ack_o=1, err_o=1, data_o=0.
    - Deassert bus_stb_o, bus_we_o and bus_select_o.
    - Go to DONE.
  - Otherwise increment the counter.
- DONE:
  - ack_o (and err_o, if set) is high for exactly this one cycle.
  - last_grant is set to the granted master.
  - Go to IDLE unconditionally; ack_o, err_o and grant_o clear at the next edge.
  - Requests are not sampled in DONE. This prevents a master that is still holding req in its ack cycle from being re-granted.
- The non-granted master's ack_o, err_o and data_o stay 0 throughout.
- Minimum turnaround with a zero-wait slave (ack in the first BUSY cycle): req at N, stb at N+1, ack_o at N+2, IDLE at N+3. The next grant's stb appears at N+4.
- Under continuous contention with FIXED_PRIO=0, grants strictly alternate m0, m1, m0, …
- If req drops during BUSY, the transaction still completes and ack is still delivered (no abort).
- If a transaction takes exactly TIMEOUT cycles, completion is decided by bus_ack_i in that final cycle: if ack is asserted, the result is normal completion (err=0). Ack takes precedence.
- Counter width is 16 bits; it never wraps, because TIMEOUT ≤ 65535.

Test Plan:
- Single read: m0_req_i=1, addr=0x0000_0100, slave acks the 3rd BUSY cycle with data 0xDEADBEEF. Required: m0_ack_o high for 1 cycle with m0_data_o=0xDEADBEEF, m0_err_o=0, grant_o returns to 00 after 2 more cycles.
- Simultaneous requests: both req from reset, FIXED_PRIO=0, zero-wait slave, 4 transactions. Required: grant order m0, m1, m0, m1; bus_addr_o matches the owner's addr each time; no duplicate grant.
- Fixed priority: FIXED_PRIO=1, both req continuously. Required: m0 is granted every time; m1 is never granted until m0_req_i drops.
- Timeout: TIMEOUT=8, m1 write, bus_ack_i never asserted. Required: m1_ack_o=1 and m1_err_o=1 exactly 8 cycles after bus_stb_o rises, bus_stb_o=0 afterwards, then IDLE.
- Isolation and hold: m0 granted; in BUSY, m0_addr_i changes and m1_req_i rises. Required: bus_addr_o is unchanged, m1_ack_o stays 0, and m1 is granted only after DONE.
- Reset mid-op: rst=0 asserted while in BUSY. Required: bus_stb_o, grant_o and all ack_o go to 0 asynchronously; after release, the first tie goes to m0.
